// File: rtl/dmem_responder.sv
// Data-memory responder: one outstanding load/store over valid/ready handshakes,
// with a fixed access latency and RV32I DMCtrl byte/half/word semantics.
module dmem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [2:0]  req_ctrl_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o
);
  localparam int         AW       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [2:0]  ctrl_q, ctrl_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic [31:0] mem_q [DEPTH_WORDS];

  logic [AW-1:0] widx;
  logic [31:0]   rword;
  logic [7:0]    bsel;
  logic [15:0]   hsel;
  logic [31:0]   ld_data;
  logic [3:0]    be;
  logic [31:0]   st_data;
  logic          illegal;
  logic          do_access;
  logic          mem_we;

  assign widx  = addr_q[AW+1:2];
  assign rword = mem_q[widx];
  assign bsel  = rword[{addr_q[1:0], 3'b000} +: 8];
  assign hsel  = addr_q[1] ? rword[31:16] : rword[15:0];

  // Legality is judged on the latched request only.
  always_comb begin
    illegal = 1'b0;
    case (ctrl_q)
      3'b011, 3'b110, 3'b111: illegal = 1'b1;
      default: ;
    endcase
    if (we_q && ctrl_q[2])                           illegal = 1'b1;
    if (ctrl_q[1:0] == 2'b01 && addr_q[0])           illegal = 1'b1;
    if (ctrl_q == 3'b010 && addr_q[1:0] != 2'b00)    illegal = 1'b1;
    if (addr_q[31:2] >= 30'(DEPTH_WORDS))            illegal = 1'b1;
  end

  always_comb begin
    case (ctrl_q)
      3'b000:  ld_data = {{24{bsel[7]}}, bsel};
      3'b001:  ld_data = {{16{hsel[15]}}, hsel};
      3'b100:  ld_data = {24'h0, bsel};
      3'b101:  ld_data = {16'h0, hsel};
      default: ld_data = rword;
    endcase
  end

  always_comb begin
    case (ctrl_q[1:0])
      2'b00: begin
        be      = 4'b0001 << addr_q[1:0];
        st_data = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        be      = addr_q[1] ? 4'b1100 : 4'b0011;
        st_data = {2{wdata_q[15:0]}};
      end
      default: begin
        be      = 4'b1111;
        st_data = wdata_q;
      end
    endcase
  end

  assign do_access = (state_q == S_WAIT) && (cnt_q == 4'd0);
  // A reset landing on the access edge must abandon the store.
  assign mem_we    = do_access && we_q && !illegal && rst_n;

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem_q[widx][8*i +: 8] <= st_data[8*i +: 8];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    ctrl_d  = ctrl_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid_i) begin
          we_d    = req_we_i;
          ctrl_d  = req_ctrl_i;
          addr_d  = req_addr_i;
          wdata_d = req_wdata_i;
          cnt_d   = CNT_INIT;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          rdata_d = (we_q || illegal) ? 32'h0 : ld_data;
          err_d   = illegal;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        if (rsp_ready_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      ctrl_q  <= 3'b000;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      ctrl_q  <= ctrl_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign req_ready_o = (state_q == S_IDLE);
  assign rsp_valid_o = (state_q == S_RESP);
  assign rsp_rdata_o = rdata_q;
  assign rsp_err_o   = err_q;
endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: instance 0 has LATENCY=2, 1 has 1, 2 has 4.
module tb_dmem_responder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [2:0]       rv = '0, rr = '0, we = '0;
  logic [2:0]       rdy, vld, er;
  logic [2:0][2:0]  ctl = '0;
  logic [2:0][31:0] ad = '0, wd = '0;
  logic [2:0][31:0] rd;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    dmem_responder #(
      .DEPTH_WORDS(256),
      .LATENCY((g == 0) ? 2 : (g == 1) ? 1 : 4)
    ) u_dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid_i(rv[g]), .req_ready_o(rdy[g]), .req_we_i(we[g]),
      .req_ctrl_i(ctl[g]), .req_addr_i(ad[g]), .req_wdata_i(wd[g]),
      .rsp_valid_o(vld[g]), .rsp_ready_i(rr[g]),
      .rsp_rdata_o(rd[g]), .rsp_err_o(er[g])
    );
  end

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        we;
    logic [2:0]  ctl;
    logic [31:0] ad;
    logic [31:0] wd;
    logic [31:0] erd;
    logic        eer;
  } vec_t;
  vec_t tv[$];

  task automatic addv(input logic w, input logic [2:0] c, input logic [31:0] a, d, erd,
                      input logic eer);
    vec_t v;
    v.we = w; v.ctl = c; v.ad = a; v.wd = d; v.erd = erd; v.eer = eer;
    tv.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Issue one request on instance k, measure edges to rsp_valid, then complete it.
  task automatic xact(input int k, input logic w, input logic [2:0] c, input logic [31:0] a, d,
                      output logic [31:0] r, output logic e, output int lat);
    rv[k] = 1'b1; we[k] = w; ctl[k] = c; ad[k] = a; wd[k] = d;
    @(posedge clk); #1;
    rv[k] = 1'b0; we[k] = ~w; ad[k] = ~a; wd[k] = ~d;
    lat = 0;
    while (!vld[k] && lat < 40) begin @(posedge clk); #1; lat++; end
    r = rd[k]; e = er[k];
    rr[k] = 1'b1;
    @(posedge clk); #1;
    rr[k] = 1'b0;
  endtask

  initial begin
    logic [31:0] r;
    logic        e;
    int          lat;

    addv(1, 3'b010, 32'h10,  32'hDEADBEEF, 32'h0,        0);
    addv(0, 3'b010, 32'h10,  32'h0,        32'hDEADBEEF, 0);
    addv(1, 3'b000, 32'h13,  32'h00000080, 32'h0,        0);
    addv(0, 3'b000, 32'h13,  32'h0,        32'hFFFFFF80, 0);
    addv(0, 3'b100, 32'h13,  32'h0,        32'h00000080, 0);
    addv(0, 3'b010, 32'h10,  32'h0,        32'h80ADBEEF, 0);
    addv(0, 3'b000, 32'h12,  32'h0,        32'hFFFFFFAD, 0);
    addv(0, 3'b101, 32'h12,  32'h0,        32'h000080AD, 0);
    addv(1, 3'b001, 32'h22,  32'h00001234, 32'h0,        0);
    addv(0, 3'b101, 32'h22,  32'h0,        32'h00001234, 0);
    addv(0, 3'b001, 32'h21,  32'h0,        32'h0,        1);
    addv(1, 3'b010, 32'h11,  32'hFFFFFFFF, 32'h0,        1);
    addv(0, 3'b010, 32'h10,  32'h0,        32'h80ADBEEF, 0);
    addv(0, 3'b010, 32'h400, 32'h0,        32'h0,        1);
    addv(0, 3'b011, 32'h0,   32'h0,        32'h0,        1);
    addv(1, 3'b100, 32'h0,   32'h000000AA, 32'h0,        1);
    addv(1, 3'b001, 32'h20,  32'h00008001, 32'h0,        0);
    addv(0, 3'b001, 32'h20,  32'h0,        32'hFFFF8001, 0);
    addv(0, 3'b010, 32'h20,  32'h0,        32'h12348001, 0);
    addv(0, 3'b010, 32'h22,  32'h0,        32'h0,        1);
    addv(1, 3'b010, 32'h3FC, 32'hCAFEF00D, 32'h0,        0);
    addv(0, 3'b010, 32'h3FC, 32'h0,        32'hCAFEF00D, 0);
    addv(0, 3'b000, 32'h3FF, 32'h0,        32'hFFFFFFCA, 0);

    // Reset held with a request pending: nothing may be accepted.
    rv = 3'b111; we = 3'b111; ctl = {3{3'b010}}; ad = {3{32'h10}}; wd = {3{32'h5A5A5A5A}};
    repeat (3) begin
      @(posedge clk); #1;
      chk("rst vld", {31'b0, vld[0]}, 32'd0);
    end
    rv = '0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst rdy",   {31'b0, rdy[0]}, 32'd1);
    chk("rst vld2",  {31'b0, vld[0]}, 32'd0);
    chk("rst rdata", rd[0], 32'h0);
    chk("rst err",   {31'b0, er[0]}, 32'd0);

    for (int i = 0; i < tv.size(); i++) begin
      xact(0, tv[i].we, tv[i].ctl, tv[i].ad, tv[i].wd, r, e, lat);
      chk($sformatf("v%0d rdata", i), r, tv[i].erd);
      chk($sformatf("v%0d err", i), {31'b0, e}, {31'b0, tv[i].eer});
      chk($sformatf("v%0d lat", i), 32'(lat), 32'd2);
    end

    // Latency 1 and 4 instances.
    for (int k = 1; k < 3; k++) begin
      xact(k, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, r, e, lat);
      chk($sformatf("L%0d sw lat", k), 32'(lat), (k == 1) ? 32'd1 : 32'd4);
      xact(k, 1'b0, 3'b010, 32'h10, 32'h0, r, e, lat);
      chk($sformatf("L%0d lw rdata", k), r, 32'hDEADBEEF);
      chk($sformatf("L%0d lw lat", k), 32'(lat), (k == 1) ? 32'd1 : 32'd4);
    end

    // Backpressure: response held while a new request waits on the bus.
    rv[0] = 1'b1; we[0] = 1'b0; ctl[0] = 3'b010; ad[0] = 32'h10; wd[0] = 32'h0;
    @(posedge clk); #1;
    we[0] = 1'b1; ad[0] = 32'h40; wd[0] = 32'h55555555;
    lat = 0;
    while (!vld[0] && lat < 40) begin @(posedge clk); #1; lat++; end
    chk("bp lat", 32'(lat), 32'd2);
    for (int i = 0; i < 5; i++) begin
      chk("bp vld",   {31'b0, vld[0]}, 32'd1);
      chk("bp rdata", rd[0], 32'h80ADBEEF);
      chk("bp err",   {31'b0, er[0]}, 32'd0);
      chk("bp rdy",   {31'b0, rdy[0]}, 32'd0);
      @(posedge clk); #1;
    end
    rr[0] = 1'b1;
    @(posedge clk); #1;
    rr[0] = 1'b0;
    chk("bp rdy back", {31'b0, rdy[0]}, 32'd1);
    chk("bp vld drop", {31'b0, vld[0]}, 32'd0);
    @(posedge clk); #1;
    rv[0] = 1'b0;
    lat = 0;
    while (!vld[0] && lat < 40) begin @(posedge clk); #1; lat++; end
    chk("bp2 lat", 32'(lat), 32'd2);
    chk("bp2 err", {31'b0, er[0]}, 32'd0);
    rr[0] = 1'b1;
    @(posedge clk); #1;
    rr[0] = 1'b0;
    xact(0, 1'b0, 3'b010, 32'h40, 32'h0, r, e, lat);
    chk("bp2 readback", r, 32'h55555555);

    // Reset arriving on the access edge abandons the store.
    xact(0, 1'b1, 3'b010, 32'h30, 32'h22222222, r, e, lat);
    rv[0] = 1'b1; we[0] = 1'b1; ctl[0] = 3'b010; ad[0] = 32'h30; wd[0] = 32'h11111111;
    @(posedge clk); #1;
    rv[0] = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("rw rdy",   {31'b0, rdy[0]}, 32'd1);
    chk("rw rdata", rd[0], 32'h0);
    for (int i = 0; i < 4; i++) begin
      chk("rw no rsp", {31'b0, vld[0]}, 32'd0);
      @(posedge clk); #1;
    end
    xact(0, 1'b0, 3'b010, 32'h30, 32'h0, r, e, lat);
    chk("rw readback", r, 32'h22222222);
    chk("rw lat", 32'(lat), 32'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end
endmodule
